// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper: steps the 4-bit stimulus {w,x,y,z} through 0..15.
// Each value is held for a settle time. The breadboard response is then
// captured and streamed out as {idx,data} rows over a valid/ready handshake.
// Optional feature macro: BB_SIGNATURE_EN enables a running 16-bit rotate-xor
// signature of the emitted rows. Without it, sig is tied to zero.
//
// state  | meaning
// IDLE   | waiting for start; stimulus holds its last value
// DRIVE  | stimulus = idx, settle counter running
// SAMPLE | capture resp and idx into the row registers
// EMIT   | row_valid high until the consumer accepts the row
// FIN    | one-cycle done pulse, then back to IDLE
module breadboard_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter int RESP_W        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              w,
    output logic              x,
    output logic              y,
    output logic              z,
    input  logic [RESP_W-1:0] resp,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [3:0]        row_idx,
    output logic [RESP_W-1:0] row_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sig
);

    // A settle time of zero would skip DRIVE entirely, so it is clamped to one cycle.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        EMIT   = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             handshake;

    assign handshake = (state == EMIT) && row_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next = state;
        row_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = EMIT;
            end
            EMIT: begin
                row_valid = 1'b1;
                if (row_ready) begin
                    state_next = (idx == 4'hF) ? FIN : DRIVE;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Index and settle counter. idx only moves on DRIVE entry, so the stimulus is
    // constant through SAMPLE and EMIT, and it holds 4'hF after the last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 4'h0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= 4'h0;
                        cnt <= '0;
                    end
                end
                DRIVE: begin
                    cnt <= cnt + 1'b1;
                end
                EMIT: begin
                    if (row_ready && (idx != 4'hF)) begin
                        idx <= idx + 4'h1;
                        cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Row capture. The row registers are only written in SAMPLE, so they stay
    // stable for the whole time the row is being offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx  <= 4'h0;
            row_data <= '0;
        end else if (state == SAMPLE) begin
            row_idx  <= idx;
            row_data <= resp;
        end
    end

    assign {w, x, y, z} = idx;

`ifdef BB_SIGNATURE_EN
    logic [15:0] row_ext;
    assign row_ext = 16'(row_data);

    // Running signature: rotate left by one, then fold in each accepted row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= 16'h0000;
        end else if ((state == IDLE) && start) begin
            sig <= 16'h0000;
        end else if (handshake) begin
            sig <= {sig[14:0], sig[15]} ^ row_ext;
        end
    end
`else
    logic unused_sig;
    assign unused_sig = handshake;
    assign sig        = 16'h0000;
`endif

endmodule
